rp_acq_wr: RTL and testbench

- Acquisition write controller directly downstream of the ADC decimator.
- Takes the decimated sample stream (valid + data) and writes it into a circular BRAM buffer.
- Implements the arm / pre-trigger / trigger / post-trigger-delay sequence.
- Reports the buffer address of the trigger sample and the acquisition status to the register bank.

---
 rtl/rp_acq_wr_pkg.sv | 26 ++
 rtl/rp_acq_wr.sv | 139 +++++++++++++
 tb/tb_rp_acq_wr.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rp_acq_wr_pkg.sv
// Shared definitions for the acquisition write controller: FSM encoding,
// counter width and a saturating-increment helper.
package rp_acq_wr_pkg;

  localparam int unsigned CW = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } acq_state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    logic [CW-1:0] r;
    r = v;
    if (en && (v != {CW{1'b1}})) r = v + CW'(1);
    return r;
  endfunction

  function automatic logic is_armed(input acq_state_t s);
    return (s == ST_PRE) || (s == ST_WAIT_TRIG) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/rp_acq_wr.sv
// Acquisition write controller: streams decimated samples into a circular
// buffer and runs the arm / pre-trigger / trigger / post-trigger sequence.
module rp_acq_wr
  import rp_acq_wr_pkg::*;
#(
  parameter int unsigned DW = 14,
  parameter int unsigned AW = 14
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          dec_val_i,
  input  logic [DW-1:0] dec_dat_i,
  input  logic          arm_i,
  input  logic          stop_i,
  input  logic          trig_i,
  input  logic [CW-1:0] set_pre_i,
  input  logic [CW-1:0] set_dly_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_dat_o,
  output logic [AW-1:0] trig_addr_o,
  output logic          armed_o,
  output logic          trig_det_o,
  output logic          done_o,
  output logic [CW-1:0] pre_cnt_o
);

  acq_state_t    r_state;
  acq_state_t    w_state_nxt;

  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_dat;
  logic          r_wr_en;

  logic [AW-1:0] r_trig_addr;
  logic          r_armed;
  logic          r_trig_det;
  logic          r_done;
  logic [CW-1:0] r_pre_cnt;
  logic [CW-1:0] r_post_cnt;

  logic          w_cnt_en;
  logic [CW-1:0] w_pre_nxt;
  logic [CW-1:0] w_post_nxt;
  logic          w_arm;
  logic          w_trig_acc;
  logic          w_done_set;

  // State register
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state: stop > arm > trigger > counter compares
  always_comb begin
    w_state_nxt = r_state;
    if (stop_i) begin
      w_state_nxt = ST_IDLE;
    end else if (arm_i) begin
      w_state_nxt = (set_pre_i == '0) ? ST_WAIT_TRIG : ST_PRE;
    end else begin
      case (r_state)
        ST_PRE:       if (w_pre_nxt >= set_pre_i)  w_state_nxt = ST_WAIT_TRIG;
        ST_WAIT_TRIG: if (trig_i)                  w_state_nxt = ST_POST;
        ST_POST:      if (w_post_nxt >= set_dly_i) w_state_nxt = ST_DONE;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  // Output/event decode; compares use the count including this cycle's sample
  always_comb begin
    w_cnt_en   = is_armed(r_state) & dec_val_i;
    w_pre_nxt  = sat_inc(r_pre_cnt, w_cnt_en);
    w_post_nxt = sat_inc(r_post_cnt, (r_state == ST_POST) & dec_val_i);
    w_arm      = arm_i & ~stop_i;
    w_trig_acc = (r_state == ST_WAIT_TRIG) & trig_i & ~arm_i & ~stop_i;
    w_done_set = (r_state == ST_POST) & (w_post_nxt >= set_dly_i) & ~arm_i & ~stop_i;
  end

  // Write path: one-cycle latency, runs regardless of acquisition state
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_wp      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_dat  <= '0;
    end else begin
      r_wr_en <= dec_val_i;
      if (dec_val_i) begin
        r_wr_addr <= r_wp;
        r_wr_dat  <= dec_dat_i;
        r_wp      <= r_wp + AW'(1);
      end
    end
  end

  // Status and counters; stop keeps the sticky flags and the pre count
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_armed     <= 1'b0;
      r_trig_addr <= '0;
      r_trig_det  <= 1'b0;
      r_done      <= 1'b0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
    end else begin
      r_armed <= is_armed(w_state_nxt);
      if (w_trig_acc) r_trig_addr <= r_wp;

      if (w_arm) begin
        r_trig_det <= 1'b0;
        r_done     <= 1'b0;
        r_pre_cnt  <= '0;
      end else begin
        if (w_trig_acc) r_trig_det <= 1'b1;
        if (w_done_set) r_done     <= 1'b1;
        if (!stop_i)    r_pre_cnt  <= w_pre_nxt;
      end

      // The sample arriving with the trigger is post sample #1
      if (stop_i || arm_i)  r_post_cnt <= '0;
      else if (w_trig_acc)  r_post_cnt <= CW'(dec_val_i);
      else                  r_post_cnt <= w_post_nxt;
    end
  end

  assign wr_en_o     = r_wr_en;
  assign wr_addr_o   = r_wr_addr;
  assign wr_dat_o    = r_wr_dat;
  assign trig_addr_o = r_trig_addr;
  assign armed_o     = r_armed;
  assign trig_det_o  = r_trig_det;
  assign done_o      = r_done;
  assign pre_cnt_o   = r_pre_cnt;

endmodule

// File: tb/tb_rp_acq_wr.sv
// Scoreboard bench for rp_acq_wr: a cycle-level reference model predicts the
// write stream and status; a monitor compares them against the DUT each cycle.
module tb_rp_acq_wr;

  localparam int unsigned DW    = 14;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          val;
  logic [DW-1:0] dat;
  logic          arm;
  logic          stop;
  logic          trig;
  logic [31:0]   set_pre;
  logic [31:0]   set_dly;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_dat_o;
  logic [AW-1:0] trig_addr_o;
  logic          armed_o;
  logic          trig_det_o;
  logic          done_o;
  logic [31:0]   pre_cnt_o;

  always #5 clk = ~clk;

  rp_acq_wr #(.DW(DW), .AW(AW)) dut (
    .adc_clk_i   (clk),
    .adc_rst_i   (rst),
    .dec_val_i   (val),
    .dec_dat_i   (dat),
    .arm_i       (arm),
    .stop_i      (stop),
    .trig_i      (trig),
    .set_pre_i   (set_pre),
    .set_dly_i   (set_dly),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_dat_o    (wr_dat_o),
    .trig_addr_o (trig_addr_o),
    .armed_o     (armed_o),
    .trig_det_o  (trig_det_o),
    .done_o      (done_o),
    .pre_cnt_o   (pre_cnt_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  typedef struct {
    bit     wr_en;
    bit     armed;
    bit     det;
    bit     done;
    int     taddr;
    longint pre;
  } st_t;

  typedef enum int {M_IDLE, M_FILL, M_WAIT, M_CAPT, M_CMPL} mph_t;

  wr_t wq[$];
  st_t sq[$];
  int  n_vec = 0;
  int  n_err = 0;

  mph_t   m_ph;
  int     m_wp;
  longint m_pre;
  longint m_post;
  bit     m_det;
  bit     m_done;
  int     m_taddr;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and predict the outputs after the next edge
  task automatic step(input bit r, input bit v, input logic [DW-1:0] d,
                      input bit a, input bit s, input bit t);
    st_t e;
    wr_t w;
    int  wp_now;
    bit  active;
    rst = r; val = v; dat = d; arm = a; stop = s; trig = t;
    e.wr_en = 1'b0;
    if (r) begin
      m_ph = M_IDLE; m_wp = 0; m_pre = 0; m_post = 0;
      m_det = 0; m_done = 0; m_taddr = 0;
    end else begin
      wp_now  = m_wp;
      active  = (m_ph == M_FILL) || (m_ph == M_WAIT) || (m_ph == M_CAPT);
      e.wr_en = v;
      if (v) begin
        w.addr = AW'(m_wp);
        w.dat  = d;
        wq.push_back(w);
        m_wp = (m_wp + 1) % DEPTH;
      end
      if (s) begin
        m_ph = M_IDLE;
        m_post = 0;
      end else if (a) begin
        m_pre = 0; m_post = 0; m_det = 0; m_done = 0;
        m_ph = (set_pre == 0) ? M_WAIT : M_FILL;
      end else begin
        if (active && v && m_pre < 64'hFFFF_FFFF) m_pre++;
        case (m_ph)
          M_FILL: if (m_pre >= longint'(set_pre)) m_ph = M_WAIT;
          M_WAIT: if (t) begin
            m_taddr = wp_now;
            m_det   = 1;
            m_post  = v ? 1 : 0;
            m_ph    = M_CAPT;
          end
          M_CAPT: begin
            if (v) m_post++;
            if (m_post >= longint'(set_dly)) begin
              m_ph = M_CMPL;
              m_done = 1;
            end
          end
          default: ;
        endcase
      end
    end
    e.armed = (m_ph == M_FILL) || (m_ph == M_WAIT) || (m_ph == M_CAPT);
    e.det   = m_det;
    e.done  = m_done;
    e.taddr = m_taddr;
    e.pre   = m_pre;
    sq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic sample(input int n);
    for (int i = 0; i < n; i++) step(0, 1, DW'($urandom), 0, 0, 0);
  endtask

  // Monitor: compare predicted status every cycle, pop writes on wr_en_o
  st_t me;
  wr_t mw;
  always @(negedge clk) begin
    if (sq.size() > 0) begin
      me = sq.pop_front();
      chk("wr_en",     longint'(wr_en_o),     longint'(me.wr_en));
      chk("armed",     longint'(armed_o),     longint'(me.armed));
      chk("trig_det",  longint'(trig_det_o),  longint'(me.det));
      chk("done",      longint'(done_o),      longint'(me.done));
      chk("trig_addr", longint'(trig_addr_o), longint'(me.taddr));
      chk("pre_cnt",   longint'(pre_cnt_o),   me.pre);
      if (wr_en_o) begin
        if (wq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wr_unexpected: got write addr %0h with none expected at %0t",
                   wr_addr_o, $time);
        end else begin
          mw = wq.pop_front();
          chk("wr_addr", longint'(wr_addr_o), longint'(mw.addr));
          chk("wr_dat",  longint'(wr_dat_o),  longint'(mw.dat));
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1; val = 0; dat = '0; arm = 0; stop = 0; trig = 0;
    set_pre = 0; set_dly = 0;
    #1;
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);

    // Five samples after reset
    for (int i = 1; i <= 5; i++) step(0, 1, DW'(i), 0, 0, 0);
    idle(2);

    // Wrap-around of the circular pointer
    step(1, 0, '0, 0, 0, 0);
    sample(20);
    idle(2);

    // Pre-trigger gating: early trigger ignored, later trigger accepted
    step(1, 0, '0, 0, 0, 0);
    set_pre = 8; set_dly = 4;
    step(0, 0, '0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, DW'($urandom), 0, 0, (i == 3) || (i == 10));
    idle(3);

    // Zero pre and zero delay
    set_pre = 0; set_dly = 0;
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 0, 0, 1);
    idle(3);

    // Stop and arm together during POST, then re-arm
    set_pre = 2; set_dly = 10;
    step(0, 0, '0, 1, 0, 0);
    sample(4);
    step(0, 1, DW'($urandom), 0, 0, 1);
    sample(2);
    step(0, 1, DW'($urandom), 1, 1, 0);
    sample(3);
    step(0, 0, '0, 1, 0, 0);
    sample(3);

    // Arm and trigger together while waiting for a trigger
    set_pre = 2;
    step(0, 0, '0, 1, 0, 0);
    sample(3);
    step(0, 1, DW'($urandom), 1, 0, 1);
    sample(3);

    // Reset during POST
    set_pre = 0; set_dly = 6;
    step(0, 0, '0, 1, 0, 0);
    step(0, 1, DW'($urandom), 0, 0, 1);
    sample(2);
    step(1, 0, '0, 0, 0, 0);
    sample(3);

    // Randomized traffic with settings changing mid-acquisition
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) set_pre = 32'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) set_dly = 32'($urandom_range(0, 8));
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 3) != 0,
           DW'($urandom),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 9) == 0);
    end
    idle(3);

    guard = 0;
    while (sq.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk("status_drain", longint'(sq.size()), 0);
    chk("write_drain",  longint'(wq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
